// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared definitions for the IFU thread scheduler: thread FSM encodings,
// scheduler states and the ready/running decode helpers.
package sparc_ifu_thrsched_pkg;

  localparam logic [4:0] THRFSM_IDLE     = 5'b00000;
  localparam logic [4:0] THRFSM_HALT     = 5'b00010;
  localparam logic [4:0] THRFSM_WAIT     = 5'b00001;
  localparam logic [4:0] THRFSM_RDY      = 5'b11001;
  localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
  localparam logic [4:0] THRFSM_RUN      = 5'b00101;
  localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCHED = 2'd1,
    S_RUN   = 2'd2
  } sched_state_t;

  // Only the two legal ready encodings qualify; stray codes are ignored.
  function automatic logic thr_ready(input logic [4:0] s);
    return (s == THRFSM_RDY) || (s == THRFSM_SPEC_RDY);
  endfunction

  function automatic logic thr_running(input logic [4:0] s);
    return (s == THRFSM_RUN) || (s == THRFSM_SPEC_RUN);
  endfunction

  function automatic logic [3:0] thr_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/sparc_ifu_lru4.sv
// Four-entry least-recently-scheduled tracker with a two-class priority pick.
// Slot 0 of the order register holds the least recent thread, slot 3 the most recent.
module sparc_ifu_lru4
  import sparc_ifu_thrsched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cand,
  input  logic [3:0] prio,
  input  logic [3:0] upd,
  output logic [1:0] win_id,
  output logic       win_vld
);

  logic [7:0] order;
  logic [7:0] order_nxt;
  logic [3:0] pool;
  logic [1:0] upd_id;
  logic       found;

  // Pick the least recent thread, restricting to the priority class when it is non-empty.
  always_comb begin
    pool    = ((cand & prio) != 4'b0000) ? (cand & prio) : cand;
    win_id  = 2'd0;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (pool[order[2*k +: 2]]) begin
        win_id  = order[2*k +: 2];
        win_vld = 1'b1;
      end
    end
  end

  // Move the updated thread to the most-recent slot, sliding the younger ones down.
  always_comb begin
    order_nxt = order;
    upd_id    = 2'd0;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (upd[i]) upd_id = 2'(i);
    end
    if (upd != 4'b0000) begin
      for (int k = 0; k < 3; k++) begin
        if (order[2*k +: 2] == upd_id) found = 1'b1;
        if (found) order_nxt[2*k +: 2] = order[2*(k+1) +: 2];
      end
      order_nxt[7:6] = upd_id;
    end
  end

  // Order register; reset order is 0,1,2,3 with thread 0 least recent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) order <= {2'd3, 2'd2, 2'd1, 2'd0};
    else       order <= order_nxt;
  end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// IFU thread scheduler: picks the next thread by readiness class and LRU order,
// enforces a run quantum and honours fetch-control switch requests.
module sparc_ifu_thrsched
  import sparc_ifu_thrsched_pkg::*;
#(
  parameter int QUANTUM = 32,
  parameter int QCNT_W  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] thr_state_bus,
  input  logic        switch_req,
  input  logic        stall_all,
  output logic [3:0]  schedule,
  output logic [3:0]  switch_out,
  output logic [1:0]  cur_thr,
  output logic        cur_vld
);

  sched_state_t      state, state_nxt;
  logic [QCNT_W-1:0] qcnt, qcnt_nxt;
  logic [1:0]        cur_thr_nxt;
  logic              cur_vld_nxt;
  logic [3:0]        sched_nxt, swo_nxt;
  logic [4:0]        thr_st [4];
  logic [3:0]        ready_mask, rdy_mask, cand;
  logic              cur_running, quantum_done;
  logic [1:0]        win_id;
  logic              win_vld;

  // Decode each thread's state into ready, firm-ready and the candidate set.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      thr_st[i]     = thr_state_bus[5*i +: 5];
      ready_mask[i] = thr_ready(thr_st[i]);
      rdy_mask[i]   = (thr_st[i] == THRFSM_RDY);
    end
    cand         = ready_mask & ~((state == S_RUN) ? thr_onehot(cur_thr) : 4'b0000);
    cur_running  = thr_running(thr_st[cur_thr]);
    quantum_done = (qcnt == QCNT_W'(QUANTUM));
  end

  sparc_ifu_lru4 u_lru (
    .clk     (clk),
    .reset   (reset),
    .cand    (cand),
    .prio    (rdy_mask),
    .upd     (sched_nxt),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  // Scheduler next-state and registered-output decisions.
  always_comb begin
    state_nxt   = state;
    qcnt_nxt    = qcnt;
    cur_thr_nxt = cur_thr;
    cur_vld_nxt = cur_vld;
    sched_nxt   = 4'b0000;
    swo_nxt     = 4'b0000;
    case (state)
      S_IDLE: begin
        cur_vld_nxt = 1'b0;
        if (win_vld && !stall_all) begin
          sched_nxt   = thr_onehot(win_id);
          cur_thr_nxt = win_id;
          state_nxt   = S_SCHED;
        end
      end
      S_SCHED: begin
        if (cur_running) begin
          state_nxt   = S_RUN;
          cur_vld_nxt = 1'b1;
          qcnt_nxt    = '0;
        end else begin
          state_nxt   = S_IDLE;
          cur_vld_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall_all && !quantum_done) qcnt_nxt = qcnt + QCNT_W'(1);
        if (!cur_running) begin
          state_nxt   = S_IDLE;
          cur_vld_nxt = 1'b0;
        end else if ((switch_req || quantum_done) && win_vld && !stall_all) begin
          swo_nxt     = thr_onehot(cur_thr);
          sched_nxt   = thr_onehot(win_id);
          cur_thr_nxt = win_id;
          cur_vld_nxt = 1'b0;
          state_nxt   = S_SCHED;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        cur_vld_nxt = 1'b0;
      end
    endcase
  end

  // State, quantum counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      qcnt       <= '0;
      cur_thr    <= 2'd0;
      cur_vld    <= 1'b0;
      schedule   <= 4'b0000;
      switch_out <= 4'b0000;
    end else begin
      state      <= state_nxt;
      qcnt       <= qcnt_nxt;
      cur_thr    <= cur_thr_nxt;
      cur_vld    <= cur_vld_nxt;
      schedule   <= sched_nxt;
      switch_out <= swo_nxt;
    end
  end

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Directed bench for the IFU thread scheduler: a vector table for the basic
// schedule/switch flow plus hand sequences for quantum, stall and reset cases.
module tb_sparc_ifu_thrsched;
  import sparc_ifu_thrsched_pkg::*;

  logic        clk;
  logic        reset;
  logic [19:0] thr_state_bus;
  logic        switch_req;
  logic        stall_all;
  logic [3:0]  schedule;
  logic [3:0]  switch_out;
  logic [1:0]  cur_thr;
  logic        cur_vld;

  int checks;
  int errors;

  typedef struct {
    logic [19:0] bus;
    logic        sr;
    logic        stall;
    logic [3:0]  exp_sched;
    logic [3:0]  exp_swo;
    logic [1:0]  exp_cur;
    logic        exp_vld;
  } vec_t;

  vec_t vecs [10];

  localparam logic [4:0] I  = THRFSM_IDLE;
  localparam logic [4:0] W  = THRFSM_WAIT;
  localparam logic [4:0] R  = THRFSM_RDY;
  localparam logic [4:0] SR = THRFSM_SPEC_RDY;
  localparam logic [4:0] U  = THRFSM_RUN;

  sparc_ifu_thrsched dut (
    .clk           (clk),
    .reset         (reset),
    .thr_state_bus (thr_state_bus),
    .switch_req    (switch_req),
    .stall_all     (stall_all),
    .schedule      (schedule),
    .switch_out    (switch_out),
    .cur_thr       (cur_thr),
    .cur_vld       (cur_vld)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [19:0] bus4(input logic [4:0] s3, s2, s1, s0);
    return {s3, s2, s1, s0};
  endfunction

  function automatic vec_t mk(input logic [19:0] bus, input logic sr, input logic [3:0] es,
                              input logic [3:0] ew, input logic [1:0] ec, input logic ev);
    vec_t v;
    v.bus = bus; v.sr = sr; v.stall = 1'b0;
    v.exp_sched = es; v.exp_swo = ew; v.exp_cur = ec; v.exp_vld = ev;
    return v;
  endfunction

  // Drive inputs at the falling edge, let one rising edge pass, land on the next falling edge.
  task automatic applyStimulus(input logic [19:0] bus, input logic sr, input logic stall);
    thr_state_bus = bus;
    switch_req    = sr;
    stall_all     = stall;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] es, input logic [3:0] ew,
                             input logic [1:0] ec, input logic ev);
    checks++;
    if (schedule !== es || switch_out !== ew || cur_thr !== ec || cur_vld !== ev) begin
      errors++;
      $display("[TB] FAIL %s: got sched=%b swo=%b cur=%0d vld=%b, want sched=%b swo=%b cur=%0d vld=%b",
               name, schedule, switch_out, cur_thr, cur_vld, es, ew, ec, ev);
    end
  endtask

  task automatic doReset();
    reset         = 1'b1;
    thr_state_bus = '0;
    switch_req    = 1'b0;
    stall_all     = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", 4'b0000, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = mk(bus4(I, I, I, I), 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    vecs[1] = mk(bus4(I, R, I, I), 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0);
    vecs[2] = mk(bus4(I, U, I, I), 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1);
    vecs[3] = mk(bus4(I, W, I, I), 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    vecs[4] = mk(bus4(I, W, R, I), 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0);
    vecs[5] = mk(bus4(I, W, U, I), 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1);
    vecs[6] = mk(bus4(R, I, U, R), 1'b1, 4'b0001, 4'b0010, 2'd0, 1'b0);
    vecs[7] = mk(bus4(R, I, R, U), 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
    vecs[8] = mk(bus4(R, I, R, U), 1'b1, 4'b1000, 4'b0001, 2'd3, 1'b0);
    vecs[9] = mk(bus4(U, I, R, R), 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1);

    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].bus, vecs[i].sr, vecs[i].stall);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_sched, vecs[i].exp_swo,
                  vecs[i].exp_cur, vecs[i].exp_vld);
    end

    // Quantum expiry: firm-ready thread 3 beats speculative-ready thread 1 despite LRU.
    doReset();
    applyStimulus(bus4(I, I, I, R), 1'b0, 1'b0);
    checkOutput("q_sched0", 4'b0001, 4'b0000, 2'd0, 1'b0);
    applyStimulus(bus4(I, I, I, U), 1'b0, 1'b0);
    checkOutput("q_run0", 4'b0000, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(bus4(R, I, SR, U), 1'b0, 1'b0);
      if (i == 0 || i == 31)
        checkOutput($sformatf("q_hold%0d", i), 4'b0000, 4'b0000, 2'd0, 1'b1);
    end
    applyStimulus(bus4(R, I, SR, U), 1'b0, 1'b0);
    checkOutput("q_expire", 4'b1000, 4'b0001, 2'd3, 1'b0);

    // Lone running thread: dropped switch requests, then a switch once a candidate appears.
    doReset();
    applyStimulus(bus4(I, I, I, R), 1'b0, 1'b0);
    applyStimulus(bus4(I, I, I, U), 1'b0, 1'b0);
    checkOutput("alone_run", 4'b0000, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(bus4(I, I, I, U), (i >= 37), 1'b0);
      if (i == 38)
        checkOutput("alone_req_dropped", 4'b0000, 4'b0000, 2'd0, 1'b1);
    end
    applyStimulus(bus4(I, R, I, U), 1'b0, 1'b0);
    checkOutput("alone_switch", 4'b0100, 4'b0001, 2'd2, 1'b0);

    // Running thread drops to WAIT in the same cycle as a switch request.
    doReset();
    applyStimulus(bus4(I, I, R, I), 1'b0, 1'b0);
    checkOutput("wait_sched1", 4'b0010, 4'b0000, 2'd1, 1'b0);
    applyStimulus(bus4(I, I, U, I), 1'b0, 1'b0);
    applyStimulus(bus4(I, R, W, I), 1'b1, 1'b0);
    checkOutput("wait_no_swo", 4'b0000, 4'b0000, 2'd1, 1'b0);
    applyStimulus(bus4(I, R, W, I), 1'b0, 1'b0);
    checkOutput("wait_resched", 4'b0100, 4'b0000, 2'd2, 1'b0);

    // Stall in idle, then an asynchronous reset during S_SCHED restores LRU order.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bus4(I, R, R, R), 1'b0, 1'b1);
      checkOutput($sformatf("stall%0d", i), 4'b0000, 4'b0000, 2'd0, 1'b0);
    end
    applyStimulus(bus4(I, R, R, R), 1'b0, 1'b0);
    checkOutput("stall_release", 4'b0001, 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(bus4(I, I, R, R), 1'b0, 1'b0);
    checkOutput("lru_after_reset", 4'b0001, 4'b0000, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
